multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control FSM for the RV32I core datapath. Consumes the opcode/funct3 held in the instruction register and the ALU zero flag. Produces every enable and mux select the datapath needs: PC, IR, register file, memory request and ALU operand/op selects. Also handshakes with a variable-latency memory and counts retired instructions.

## Interface
- `WIDTH`, 32, width of the retired-instruction counter
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `opcode` in 7: `instruction[6:0]` from IR
- `funct3` in 3: `instruction[14:12]` from IR
- `alu_zero` in 1: ALU result == 0
- `mem_ready` in 1: memory completes the pending request this cycle
- `pc_en` out 1: PC register load
- `pc_src` out 1: 0 = ALU result, 1 = latched target
- `ir_en` out 1: IR load
- `regfile_wr_en` out 1: register-file write
- `wb_sel` out 2: 0 ALU, 1 memory data, 2 PC (link)
- `mem_req` out 1: memory request valid
- `mem_we` out 1: request is a write
- `addr_sel` out 1: 0 = PC, 1 = ALU result
- `alu_a_sel` out 2: 0 rs1, 1 old PC, 2 zero
- `alu_b_sel` out 2: 0 rs2, 1 immediate, 2 constant 4
- `alu_op` out 2: 0 add, 1 funct-decoded, 2 subtract (compare)
- `halted` out 1: sticky illegal-instruction flag
- `instret` out WIDTH: retired-instruction count

## Operation
- States: START, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LUI, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, HALT.
- START: all outputs 0. Goes to FETCH next cycle.
- FETCH: `mem_req`=1, `addr_sel`=0. Stays while `mem_ready`=0. In the cycle `mem_ready`=1:
  - `ir_en`=1, `pc_en`=1, `pc_src`=0, `alu_a_sel`=PC, `alu_b_sel`=4, `alu_op`=add.
  - Goes to DECODE.
- DECODE: `alu_a_sel`=1, `alu_b_sel`=1, add; the datapath latches the target. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> EXEC_LUI
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - anything else -> HALT
- EXEC_R: a=rs1, b=rs2, op=1. EXEC_I: a=rs1, b=imm, op=1. EXEC_LUI: a=zero, b=imm, op=0. All three go to ALU_WB.
- ALU_WB: `regfile_wr_en`=1, `wb_sel`=0, ALU selects held from the EXEC state. Goes to FETCH.
- MEM_ADDR: a=rs1, b=imm, add. Load -> MEM_READ; store -> MEM_WRITE.
- MEM_READ: `mem_req`=1, `addr_sel`=1; waits for `mem_ready`, then MEM_WB.
- MEM_WB: `regfile_wr_en`=1, `wb_sel`=1. Goes to FETCH.
- MEM_WRITE: `mem_req`=1, `mem_we`=1, `addr_sel`=1; waits for `mem_ready`, then FETCH.
- BRANCH: a=rs1, b=rs2, op=2.
  - funct3 000 (BEQ): taken iff `alu_zero`. funct3 001 (BNE): taken iff !`alu_zero`.
  - Taken: `pc_en`=1, `pc_src`=1. Either way goes to FETCH.
  - Any other funct3 -> HALT, no PC update.
- JUMP: `regfile_wr_en`=1, `wb_sel`=2, `pc_en`=1, `pc_src`=1. Goes to FETCH.
- HALT: absorbing; all outputs 0, `halted`=1. Only `rst` exits.
- `instret` increments by 1 on every transition into FETCH from a non-START state. Wraps modulo 2^WIDTH.
- Memory handshake:
  - `mem_req`, `mem_we` and `addr_sel` stay stable while waiting.
  - `mem_ready` is ignored when `mem_req`=0.
  - `mem_ready` asserted the same cycle as `mem_req` completes in that cycle.
- Outputs not listed for a state are 0.

## Timing
- Reset:
  - While `rst`=1: state=START, `instret`=0, `halted`=0, all outputs 0.
  - First rising edge after release: START -> FETCH.
- Cycles per instruction, zero-wait memory: R/I/LUI 4, load 5, store 4, branch 3, JAL 3. Each memory wait cycle adds 1.
- FETCH-exit enables are Mealy on `mem_ready`. All other outputs are Moore on state.
- `rst` asserted mid-instruction or mid-handshake:
  - Immediate return to START, outputs 0 in the same cycle.
  - An outstanding memory request is dropped.

## Structure
- Shared package `CTRL_PKG` holds:
  - `ctrl_state_t` enum
  - opcode constants (`OP_R`, `OP_I`, `OP_LUI`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`)
  - select enums `alu_a_sel_t`, `alu_b_sel_t`, `alu_op_t`, `wb_sel_t`
- The datapath imports the same package.
- One sub-module: the existing `register` instance for the `instret` counter, with `d=instret+1` and `en` = retire strobe.

## Test plan
- Reset: `rst`=1 -> all outputs 0, `instret`=0. Release -> START, then FETCH with `mem_req`=1.
- R-type, opcode 0110011, zero-wait memory -> 4 cycles; `regfile_wr_en` for exactly 1 cycle in ALU_WB; `instret` 0 -> 1.
- Load with `mem_ready` delayed 3 cycles in MEM_READ:
  - `mem_req`=1 and `addr_sel`=1 stable for 4 cycles.
  - `wb_sel`=1 write next cycle.
  - Total 8 cycles.
- BEQ, `alu_zero`=1 -> `pc_en`=`pc_src`=1 in BRANCH. BNE, `alu_zero`=1 -> no `pc_en`. Both retire in 3 cycles.
- Illegal opcode 0000000 -> HALT, `halted`=1, all outputs 0 for 10+ cycles, `instret` unchanged.
- `rst` pulsed during MEM_WRITE wait -> outputs 0 that cycle. Restart from START.
- `instret` preset near all-ones (WIDTH=4: 15) -> next retire gives 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared control definitions for the RV32I multicycle core: FSM states, opcodes,
// datapath select encodings and the decoded control-word struct.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_ALU_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_HALT
  } ctrl_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_sel_t;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} alu_b_sel_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_FUNCT = 2'd1, ALU_SUB = 2'd2} alu_op_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2} wb_sel_t;

  typedef struct packed {
    alu_a_sel_t a;
    alu_b_sel_t b;
    alu_op_t    op;
  } alu_sel_t;

  typedef struct packed {
    logic     pc_en;
    logic     pc_src;
    logic     ir_en;
    logic     regfile_wr_en;
    wb_sel_t  wb_sel;
    logic     mem_req;
    logic     mem_we;
    logic     addr_sel;
    alu_sel_t alu;
    logic     halted;
  } ctrl_out_t;

  function automatic ctrl_state_t decode_next(input logic [6:0] op);
    case (op)
      OP_R:               return S_EXEC_R;
      OP_I:               return S_EXEC_I;
      OP_LUI:             return S_EXEC_LUI;
      OP_LOAD, OP_STORE:  return S_MEM_ADDR;
      OP_BRANCH:          return S_BRANCH;
      OP_JAL:             return S_JUMP;
      default:            return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_register.sv
// Plain enabled register with asynchronous active-high clear.
module multicycle_ctrl_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: Moore outputs per state, Mealy FETCH-exit enables on mem_ready.
// Memory waits hold the request stable; reset drops any outstanding request at once.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             ir_en,
  output logic             regfile_wr_en,
  output logic [1:0]       wb_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic [WIDTH-1:0] instret
);

  ctrl_state_t state_q, state_d;
  alu_sel_t    exec_sel_q;
  ctrl_out_t   ctrl;
  logic        br_known;
  logic        br_taken;
  logic        retire;

  assign br_known = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
  assign br_taken = (funct3 == F3_BEQ) ? alu_zero : !alu_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:     state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = decode_next(opcode);
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_LUI:  state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_BRANCH:    state_d = br_known ? S_FETCH : S_HALT;
      S_JUMP:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_en  = 1'b1;
          ctrl.pc_en  = 1'b1;
          ctrl.alu.a  = A_PC;
          ctrl.alu.b  = B_FOUR;
          ctrl.alu.op = ALU_ADD;
        end
      end
      S_DECODE: begin
        ctrl.alu.a  = A_PC;
        ctrl.alu.b  = B_IMM;
        ctrl.alu.op = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu.a  = A_RS1;
        ctrl.alu.b  = B_RS2;
        ctrl.alu.op = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu.a  = A_RS1;
        ctrl.alu.b  = B_IMM;
        ctrl.alu.op = ALU_FUNCT;
      end
      S_EXEC_LUI: begin
        ctrl.alu.a  = A_ZERO;
        ctrl.alu.b  = B_IMM;
        ctrl.alu.op = ALU_ADD;
      end
      S_ALU_WB: begin
        ctrl.regfile_wr_en = 1'b1;
        ctrl.wb_sel        = WB_ALU;
        ctrl.alu           = exec_sel_q;
      end
      S_MEM_ADDR: begin
        ctrl.alu.a  = A_RS1;
        ctrl.alu.b  = B_IMM;
        ctrl.alu.op = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.regfile_wr_en = 1'b1;
        ctrl.wb_sel        = WB_MEM;
      end
      S_MEM_WRITE: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.addr_sel = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu.a  = A_RS1;
        ctrl.alu.b  = B_RS2;
        ctrl.alu.op = ALU_SUB;
        if (br_known && br_taken) begin
          ctrl.pc_en  = 1'b1;
          ctrl.pc_src = 1'b1;
        end
      end
      S_JUMP: begin
        ctrl.regfile_wr_en = 1'b1;
        ctrl.wb_sel        = WB_PC;
        ctrl.pc_en         = 1'b1;
        ctrl.pc_src        = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // ALU_WB keeps driving the operand selects chosen by whichever EXEC state preceded it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_sel_q <= '0;
    end else if (state_q == S_EXEC_R || state_q == S_EXEC_I || state_q == S_EXEC_LUI) begin
      exec_sel_q <= ctrl.alu;
    end
  end

  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_START);

  multicycle_ctrl_register #(.WIDTH(WIDTH)) u_instret (
    .clk  (clk),
    .rst  (rst),
    .en_i (retire),
    .d_i  (instret + {{(WIDTH-1){1'b0}}, 1'b1}),
    .q_o  (instret)
  );

  assign pc_en         = ctrl.pc_en;
  assign pc_src        = ctrl.pc_src;
  assign ir_en         = ctrl.ir_en;
  assign regfile_wr_en = ctrl.regfile_wr_en;
  assign wb_sel        = ctrl.wb_sel;
  assign mem_req       = ctrl.mem_req;
  assign mem_we        = ctrl.mem_we;
  assign addr_sel      = ctrl.addr_sel;
  assign alu_a_sel     = ctrl.alu.a;
  assign alu_b_sel     = ctrl.alu.b;
  assign alu_op        = ctrl.alu.op;
  assign halted        = ctrl.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl (4-bit instret so wrap is reachable).
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LUI_OP = 7'b0110111;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, pc_src, ir_en, regfile_wr_en, mem_req, mem_we, addr_sel, halted;
  logic [1:0] wb_sel, alu_a_sel, alu_b_sel, alu_op;
  logic [3:0] instret;
  logic [14:0] outs;

  int n_err = 0;
  int n_checks = 0;
  logic [3:0] exp_instret = 4'd0;

  always #5 clk = ~clk;

  assign outs = {pc_en, pc_src, ir_en, regfile_wr_en, wb_sel, mem_req, mem_we,
                 addr_sel, alu_a_sel, alu_b_sel, alu_op, halted};

  multicycle_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .ir_en(ir_en),
    .regfile_wr_en(regfile_wr_en), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .halted(halted), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reset, then leave the DUT in FETCH just after the first post-release edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("start_outs", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    chk("first_fetch", 32'({mem_req, mem_we, addr_sel}), 32'b100);
    exp_instret = 4'd0;
  endtask

  // Responds to one memory phase: ready after 'w' wait cycles; random when idle.
  task automatic drive_mem(input int fw, input int dw, inout int cnt);
    if (mem_req) begin
      mem_ready = (cnt == (addr_sel ? dw : fw));
      cnt = mem_ready ? 0 : cnt + 1;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fw, input int dw);
    int exp_cyc, exp_wr, exp_pc, exp_src, exp_dreq, exp_we, taken;
    int n_wr, n_pc, n_src, n_dreq, n_we, n_ir, cnt;
    logic [1:0] exp_wb, wb_seen;
    logic [5:0] exp_sel, sel_seen, fsel_seen;
    opcode = op; funct3 = f3; alu_zero = z;
    n_wr = 0; n_pc = 0; n_src = 0; n_dreq = 0; n_we = 0; n_ir = 0; cnt = 0;
    wb_seen = 2'd3; sel_seen = 6'h3f; fsel_seen = 6'h3f;
    exp_wr = 0; exp_pc = 1; exp_src = 0; exp_dreq = 0; exp_we = 0;
    exp_wb = 2'd0; exp_sel = 6'h3f;
    case (op)
      R_OP:   begin exp_cyc = 4 + fw; exp_wr = 1; exp_sel = {2'd0, 2'd0, 2'd1}; end
      I_OP:   begin exp_cyc = 4 + fw; exp_wr = 1; exp_sel = {2'd0, 2'd1, 2'd1}; end
      LUI_OP: begin exp_cyc = 4 + fw; exp_wr = 1; exp_sel = {2'd2, 2'd1, 2'd0}; end
      LD_OP:  begin exp_cyc = 5 + fw + dw; exp_wr = 1; exp_wb = 2'd1; exp_dreq = dw + 1; end
      ST_OP:  begin exp_cyc = 4 + fw + dw; exp_dreq = dw + 1; exp_we = dw + 1; end
      BR_OP:  begin
        taken = (f3 == 3'b000) ? int'(z) : int'(!z);
        exp_cyc = 3 + fw; exp_pc = 1 + taken; exp_src = taken;
      end
      default: begin exp_cyc = 3 + fw; exp_wr = 1; exp_wb = 2'd2; exp_pc = 2; exp_src = 1; end
    endcase
    for (int c = 0; c < exp_cyc; c++) begin
      @(negedge clk);
      drive_mem(fw, dw, cnt);
      #1;
      if (pc_en) n_pc++;
      if (pc_en && pc_src) n_src++;
      if (mem_req && addr_sel) n_dreq++;
      if (mem_we) n_we++;
      if (ir_en) begin n_ir++; fsel_seen = {alu_a_sel, alu_b_sel, alu_op}; end
      if (regfile_wr_en) begin n_wr++; wb_seen = wb_sel; sel_seen = {alu_a_sel, alu_b_sel, alu_op}; end
    end
    chk("ir_en_cnt", 32'(n_ir), 32'd1);
    chk("fetch_sel", 32'(fsel_seen), 32'b01_10_00);
    chk("pc_en_cnt", 32'(n_pc), 32'(exp_pc));
    chk("pc_src_cnt", 32'(n_src), 32'(exp_src));
    chk("wr_cnt", 32'(n_wr), 32'(exp_wr));
    if (exp_wr != 0) chk("wb_sel", 32'(wb_seen), 32'(exp_wb));
    if (exp_sel != 6'h3f) chk("wb_alu_sel", 32'(sel_seen), 32'(exp_sel));
    chk("dreq_cycles", 32'(n_dreq), 32'(exp_dreq));
    chk("we_cycles", 32'(n_we), 32'(exp_we));
    @(posedge clk);
    #1;
    exp_instret = exp_instret + 4'd1;
    chk("instret", 32'(instret), 32'(exp_instret));
    chk("back_in_fetch", 32'({mem_req, mem_we, addr_sel}), 32'b100);
  endtask

  // Drives an instruction that must end in HALT, then watches HALT stay quiet.
  task automatic run_halt(input logic [6:0] op, input logic [2:0] f3, input int fw);
    int pre, bad, cnt;
    opcode = op; funct3 = f3; cnt = 0; bad = 0;
    pre = (op == BR_OP) ? 3 + fw : 2 + fw;
    for (int c = 0; c < pre; c++) begin
      @(negedge clk);
      drive_mem(fw, 0, cnt);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      alu_zero = 1'($urandom_range(0, 1));
      #1;
      if (outs !== 15'd1) bad++;
    end
    chk("halt_quiet", 32'(bad), 32'd0);
    chk("halt_instret", 32'(instret), 32'(exp_instret));
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    do_reset();

    run_instr(R_OP, 3'd0, 1'b0, 0, 0);
    run_instr(LD_OP, 3'd2, 1'b0, 0, 3);
    run_instr(BR_OP, 3'b000, 1'b1, 0, 0);
    run_instr(BR_OP, 3'b001, 1'b1, 0, 0);
    run_instr(JAL_OP, 3'd0, 1'b0, 0, 0);
    run_instr(ST_OP, 3'd2, 1'b0, 1, 2);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: op = R_OP;
        1: op = I_OP;
        2: op = LUI_OP;
        3: op = LD_OP;
        4: op = ST_OP;
        5: begin op = BR_OP; f3 = 3'b000; end
        6: begin op = BR_OP; f3 = 3'b001; end
        default: op = JAL_OP;
      endcase
      run_instr(op, f3, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 16 && exp_instret != 4'd15; i++) run_instr(I_OP, 3'd0, 1'b0, 0, 0);
    run_instr(LUI_OP, 3'd0, 1'b0, 0, 0);
    chk("instret_wrap", 32'(instret), 32'd0);

    // Reset in the middle of a stalled store.
    opcode = ST_OP;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("store_wait", 32'({mem_req, mem_we, addr_sel}), 32'b111);
    @(negedge clk); #1;
    chk("store_wait_hold", 32'({mem_req, mem_we, addr_sel}), 32'b111);
    rst = 1'b1;
    #1;
    chk("rst_mid_store", 32'(outs), 32'd0);
    chk("rst_mid_instret", 32'(instret), 32'd0);
    do_reset();
    run_instr(R_OP, 3'd0, 1'b0, 0, 0);

    run_halt(BR_OP, 3'b010, 1);
    do_reset();
    run_halt(7'b0000000, 3'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
